// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode map, status bit positions and sequencer state encoding
package alu_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] OP_NOP  = 5'h00;
  localparam logic [OPW-1:0] OP_NOT  = 5'h01;
  localparam logic [OPW-1:0] OP_AND  = 5'h02;
  localparam logic [OPW-1:0] OP_OR   = 5'h03;
  localparam logic [OPW-1:0] OP_XOR  = 5'h04;
  localparam logic [OPW-1:0] OP_INC  = 5'h05;
  localparam logic [OPW-1:0] OP_DEC  = 5'h06;
  localparam logic [OPW-1:0] OP_SHR  = 5'h07;
  localparam logic [OPW-1:0] OP_SHL  = 5'h08;
  localparam logic [OPW-1:0] OP_ADD  = 5'h09;
  localparam logic [OPW-1:0] OP_ADC  = 5'h0A;
  localparam logic [OPW-1:0] OP_SUB  = 5'h0B;
  localparam logic [OPW-1:0] OP_SBC  = 5'h0C;
  localparam logic [OPW-1:0] OP_EQ   = 5'h0D;
  localparam logic [OPW-1:0] OP_GT   = 5'h0E;
  localparam logic [OPW-1:0] OP_LT   = 5'h0F;
  localparam logic [OPW-1:0] OP_GE   = 5'h10;
  localparam logic [OPW-1:0] OP_LE   = 5'h11;
  localparam logic [OPW-1:0] OP_ROR  = 5'h12;
  localparam logic [OPW-1:0] OP_ROL  = 5'h13;
  localparam logic [OPW-1:0] OP_SWAP = 5'h14;
  localparam logic [OPW-1:0] OP_LSR  = 5'h15;
  localparam logic [OPW-1:0] OP_XSR  = 5'h16;
  localparam logic [OPW-1:0] OP_JMP  = 5'h17;
  localparam logic [OPW-1:0] OP_JZ   = 5'h18;
  localparam logic [OPW-1:0] OP_JS   = 5'h19;
  localparam logic [OPW-1:0] OP_JZS  = 5'h1A;
  localparam logic [OPW-1:0] OP_TRAP = 5'h1F;

  // status word is {C,S,Z}
  localparam int ST_Z = 0;
  localparam int ST_S = 1;
  localparam int ST_C = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_RESP0 = 3'd2,
    S_RESP1 = 3'd3,
    S_TRAP  = 3'd4
  } state_t;

  function automatic logic is_alu_op(input logic [OPW-1:0] op);
    return (op >= OP_NOT) && (op <= OP_SWAP);
  endfunction

  // which of {C,S,Z} an ALU op is allowed to overwrite
  function automatic logic [2:0] status_mask(input logic [OPW-1:0] op);
    logic [2:0] m;
    case (op)
      OP_NOT, OP_AND, OP_OR, OP_XOR,
      OP_INC, OP_DEC, OP_EQ:            m = 3'b001;
      OP_SHR, OP_SHL:                   m = 3'b101;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC:   m = 3'b111;
      OP_GT, OP_LT:                     m = 3'b010;
      OP_GE, OP_LE:                     m = 3'b011;
      default:                          m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_status_reg.sv
// rtl/alu_status_reg.sv - {C,S,Z} status flops with per-opcode update mask
module alu_status_reg
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           exec_en,
  input  logic [OPW-1:0] exec_op,
  input  logic [2:0]     flags,
  input  logic           load_en,
  input  logic           xor_en,
  input  logic [2:0]     src,
  output logic [2:0]     status
);

  logic [2:0] mask;

  assign mask = status_mask(exec_op);

  // EXEC and flow ops are never active in the same cycle; EXEC is listed first anyway
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status <= 3'b000;
    end else if (exec_en) begin
      status <= (status & ~mask) | (flags & mask);
    end else if (load_en) begin
      status <= src;
    end else if (xor_en) begin
      status <= status ^ src;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - issue controller for the 20-bit ALU: operand registers, status, result port
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int HALF  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_mode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_c,
  input  logic [WIDTH-1:0] alu_c2,
  input  logic [2:0]       alu_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [2:0]       status,
  output logic             jmp_taken,
  output logic             trap
);

  localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};

  state_t           state;
  state_t           state_nxt;
  logic             ready_en;
  logic             accept;
  logic             jump_hit;
  logic [WIDTH-1:0] res_c;
  logic [WIDTH-1:0] res_c2;
  logic [WIDTH-1:0] keep;

  assign accept  = in_valid && in_ready;
  assign alu_cin = status[ST_C];
  assign keep    = alu_mode ? {WIDTH{1'b1}} : HALF_MASK;

  always_comb begin
    jump_hit = 1'b0;
    case (in_op)
      OP_JMP:  jump_hit = 1'b1;
      OP_JZ:   jump_hit = status[ST_Z];
      OP_JS:   jump_hit = status[ST_S];
      OP_JZS:  jump_hit = status[ST_Z] | status[ST_S];
      default: jump_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ready_en holds in_ready low for the first cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      jmp_taken <= 1'b0;
      alu_op    <= '0;
      alu_mode  <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      res_c     <= '0;
      res_c2    <= '0;
    end else begin
      ready_en  <= 1'b1;
      jmp_taken <= accept && jump_hit;
      if (accept) begin
        alu_op   <= in_op;
        alu_mode <= in_mode;
        alu_a    <= in_a;
        alu_b    <= in_b;
      end
      if (state == S_EXEC) begin
        res_c  <= alu_c;
        res_c2 <= alu_c2;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    trap      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = ready_en;
        if (in_valid && ready_en) begin
          if (in_op == OP_TRAP) begin
            state_nxt = S_TRAP;
          end else if (is_alu_op(in_op)) begin
            state_nxt = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        state_nxt = S_RESP0;
      end
      S_RESP0: begin
        out_valid = 1'b1;
        out_last  = (alu_op != OP_SWAP);
        out_data  = res_c & keep;
        if (out_ready) begin
          state_nxt = (alu_op == OP_SWAP) ? S_RESP1 : S_IDLE;
        end
      end
      S_RESP1: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = res_c2 & keep;
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  alu_status_reg u_status (
    .clk     (clk),
    .rst_n   (rst_n),
    .exec_en (state == S_EXEC),
    .exec_op (alu_op),
    .flags   (alu_flags),
    .load_en (accept && (in_op == OP_LSR)),
    .xor_en  (accept && (in_op == OP_XSR)),
    .src     (in_a[2:0]),
    .status  (status)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a behavioural ALU and reference model
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_mode, out_ready;
  logic [4:0]  in_op;
  logic [19:0] in_a, in_b;
  logic [4:0]  alu_op;
  logic        alu_mode, alu_cin;
  logic [19:0] alu_a, alu_b, alu_c, alu_c2;
  logic [2:0]  alu_flags;
  logic        in_ready, out_valid, out_last, jmp_taken, trap;
  logic [19:0] out_data;
  logic [2:0]  status;

  int pass_cnt = 0;
  int total    = 0;
  logic [2:0] m_st;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(20), .HALF(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .alu_op(alu_op), .alu_mode(alu_mode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_c(alu_c), .alu_c2(alu_c2),
    .alu_flags(alu_flags), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .status(status), .jmp_taken(jmp_taken), .trap(trap)
  );

  typedef struct packed {
    logic [19:0] r;
    logic [19:0] r2;
    logic [2:0]  fl;
  } alu_res_t;

  function automatic alu_res_t alu_eval(input logic [4:0] op, input logic mode,
                                        input logic [19:0] a, input logic [19:0] b, input logic cin);
    alu_res_t o;
    logic [20:0] m, am, bm, t, ci;
    int msb, w;
    logic c, cmp;
    m   = mode ? 21'h0FFFFF : 21'h0003FF;
    msb = mode ? 19 : 9;
    w   = msb + 1;
    am  = {1'b0, a} & m;
    bm  = {1'b0, b} & m;
    ci  = {20'd0, cin};
    t = '0; c = 1'b0; cmp = 1'b0; o.r2 = 20'h5A5A5;
    case (op)
      OP_NOT:  t = ~am & m;
      OP_AND:  t = am & bm;
      OP_OR:   t = am | bm;
      OP_XOR:  t = am ^ bm;
      OP_INC:  t = (am + 21'd1) & m;
      OP_DEC:  t = (am - 21'd1) & m;
      OP_SHR:  begin t = am >> 1; c = am[0]; end
      OP_SHL:  begin t = (am << 1) & m; c = am[msb]; end
      OP_ADD:  begin t = am + bm; c = t[w]; t = t & m; end
      OP_ADC:  begin t = am + bm + ci; c = t[w]; t = t & m; end
      OP_SUB:  begin t = (am - bm) & m; c = (am < bm); end
      OP_SBC:  begin t = (am - bm - ci) & m; c = (am < bm + ci); end
      OP_EQ:   begin t = {20'd0, am == bm}; cmp = 1'b1; end
      OP_GT:   begin t = {20'd0, am > bm}; cmp = 1'b1; end
      OP_LT:   begin t = {20'd0, am < bm}; cmp = 1'b1; end
      OP_GE:   begin t = {20'd0, am >= bm}; cmp = 1'b1; end
      OP_LE:   begin t = {20'd0, am <= bm}; cmp = 1'b1; end
      OP_ROR:  begin t = am >> 1; t[msb] = am[0]; end
      OP_ROL:  begin t = (am << 1) & m; t[0] = am[msb]; end
      OP_SWAP: begin t = bm; o.r2 = am[19:0]; end
      default: t = '0;
    endcase
    o.r  = t[19:0];
    o.fl = cmp ? {1'b0, am < bm, am == bm} : {c, t[msb], t[19:0] == 20'd0};
    return o;
  endfunction

  // stand-in ALU; in half mode it leaves garbage above HALF that the sequencer must clear
  always_comb begin
    alu_res_t res;
    logic [19:0] junk;
    res       = alu_eval(alu_op, alu_mode, alu_a, alu_b, alu_cin);
    junk      = alu_mode ? 20'h00000 : (alu_a & 20'hFFC00);
    alu_c     = res.r | junk;
    alu_c2    = res.r2 | junk;
    alu_flags = res.fl;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_op(input logic [4:0] op, input logic mode, input logic [19:0] a,
                          input logic [19:0] b, output int nb, output logic [19:0] w0,
                          output logic [19:0] w1, output logic jmp);
    alu_res_t res;
    logic [19:0] m;
    m = mode ? 20'hFFFFF : 20'h003FF;
    nb = 0; w0 = '0; w1 = '0; jmp = 1'b0;
    if (op >= OP_NOT && op <= OP_SWAP) begin
      res = alu_eval(op, mode, a, b, m_st[2]);
      w0  = res.r & m;
      w1  = res.r2 & m;
      nb  = (op == OP_SWAP) ? 2 : 1;
      if (op inside {OP_NOT, OP_AND, OP_OR, OP_XOR, OP_INC, OP_DEC, OP_SHR, OP_SHL,
                     OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_EQ, OP_GE, OP_LE}) m_st[0] = res.fl[0];
      if (op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_GT, OP_LT, OP_GE, OP_LE}) m_st[1] = res.fl[1];
      if (op inside {OP_SHR, OP_SHL, OP_ADD, OP_ADC, OP_SUB, OP_SBC}) m_st[2] = res.fl[2];
    end else begin
      case (op)
        OP_LSR: m_st = a[2:0];
        OP_XSR: m_st = m_st ^ a[2:0];
        OP_JMP: jmp = 1'b1;
        OP_JZ:  jmp = m_st[0];
        OP_JS:  jmp = m_st[1];
        OP_JZS: jmp = m_st[0] | m_st[1];
        default: jmp = 1'b0;
      endcase
    end
  endtask

  // returns at the cycle after the accepting edge
  task automatic send(input logic [4:0] op, input logic mode, input logic [19:0] a, input logic [19:0] b);
    int n = 0;
    in_op = op; in_mode = mode; in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && n < 50) begin step(); n++; end
    if (!in_ready) chk("send_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic recv(input logic [19:0] ed, input logic el, input int bp, input string nm);
    int n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    if (!out_valid) begin
      chk({nm, "_timeout"}, 0, 1);
      return;
    end
    for (int h = 0; h <= bp; h++) begin
      chk({nm, "_valid"}, out_valid, 1);
      chk({nm, "_data"}, out_data, ed);
      chk({nm, "_last"}, out_last, el);
      out_ready = (h == bp);
      step();
    end
    out_ready = 1'b1;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic        mode;
    logic [19:0] a;
    logic [19:0] b;
    logic [19:0] exp_data;
    logic [2:0]  exp_st;
  } vec_t;

  initial begin
    vec_t tbl[10];
    logic [2:0]  prev;
    logic [31:0] rnd;
    logic [4:0]  op;
    logic        mode, jmp;
    logic [19:0] a, b, w0, w1;
    int          nb;

    tbl[0] = '{OP_ADD, 1'b1, 20'h00001, 20'hFFFFF, 20'h00000, 3'b101};
    tbl[1] = '{OP_ADC, 1'b1, 20'h00001, 20'h00001, 20'h00003, 3'b000};
    tbl[2] = '{OP_SUB, 1'b1, 20'h00005, 20'h00007, 20'hFFFFE, 3'b110};
    tbl[3] = '{OP_XOR, 1'b0, 20'h003FF, 20'h003FF, 20'h00000, 3'b111};
    tbl[4] = '{OP_INC, 1'b1, 20'h00004, 20'h00000, 20'h00005, 3'b110};
    tbl[5] = '{OP_SHL, 1'b0, 20'h00200, 20'h00000, 20'h00000, 3'b111};
    tbl[6] = '{OP_AND, 1'b0, 20'hFFC00, 20'hFFC00, 20'h00000, 3'b111};
    tbl[7] = '{OP_ROL, 1'b1, 20'h80001, 20'h00000, 20'h00003, 3'b111};
    tbl[8] = '{OP_GE,  1'b1, 20'h00007, 20'h00003, 20'h00001, 3'b100};
    tbl[9] = '{OP_SBC, 1'b1, 20'h0000A, 20'h00005, 20'h00004, 3'b000};

    in_valid = 1'b0; in_op = '0; in_mode = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    m_st = 3'b000;

    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_status", status, 0);
    chk("rst_trap", trap, 0);
    chk("rst_jmp", jmp_taken, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    chk("rel_in_ready_low", in_ready, 0);
    step();
    chk("rel_in_ready_high", in_ready, 1);

    for (int i = 0; i < 10; i++) begin
      prev = (i == 0) ? 3'b000 : tbl[i-1].exp_st;
      send(tbl[i].op, tbl[i].mode, tbl[i].a, tbl[i].b);
      chk("tbl_lat_exec", out_valid, 0);
      chk("tbl_cin", alu_cin, prev[2]);
      step();
      chk("tbl_lat_resp", out_valid, 1);
      recv(tbl[i].exp_data, 1'b1, 0, "tbl");
      chk("tbl_status", status, tbl[i].exp_st);
    end
    m_st = tbl[9].exp_st;

    for (int i = 0; i < 150; i++) begin
      rnd  = $urandom;
      op   = (rnd[4:0] == OP_TRAP) ? OP_NOP : rnd[4:0];
      mode = rnd[5];
      rnd  = $urandom; a = rnd[19:0];
      rnd  = $urandom; b = rnd[19:0];
      model_op(op, mode, a, b, nb, w0, w1, jmp);
      send(op, mode, a, b);
      if (nb == 0) begin
        chk("rnd_jmp", jmp_taken, jmp);
      end else begin
        recv(w0, nb == 1, $urandom_range(0, 3), "rnd_beat0");
        if (nb == 2) recv(w1, 1'b1, $urandom_range(0, 2), "rnd_beat1");
      end
      chk("rnd_status", status, m_st);
    end

    send(OP_SWAP, 1'b1, 20'h12345, 20'hABCDE);
    recv(20'hABCDE, 1'b0, 5, "swap0");
    recv(20'h12345, 1'b1, 0, "swap1");
    chk("swap_status", status, m_st);

    send(OP_LSR, 1'b1, 20'h00002, 20'h0);
    chk("lsr_status", status, 3'b010);
    chk("lsr_no_jmp", jmp_taken, 0);
    send(OP_JS, 1'b1, 20'h0, 20'h0);
    chk("js_pulse", jmp_taken, 1);
    step();
    chk("js_pulse_end", jmp_taken, 0);
    send(OP_JZ, 1'b1, 20'h0, 20'h0);
    chk("jz_no_pulse", jmp_taken, 0);
    send(OP_XSR, 1'b1, 20'h00003, 20'h0);
    chk("xsr_status", status, 3'b001);
    send(OP_JZ, 1'b1, 20'h0, 20'h0);
    chk("jz_pulse", jmp_taken, 1);
    send(5'h1C, 1'b1, 20'h00007, 20'h0);
    chk("illegal_status", status, 3'b001);
    chk("illegal_in_ready", in_ready, 1);
    m_st = 3'b001;

    send(OP_AND, 1'b0, 20'hFFC00, 20'hFFC00);
    recv(20'h00000, 1'b1, 0, "half_and");
    chk("half_and_z", status[0], 1);
    send(OP_TRAP, 1'b1, 20'h0, 20'h0);
    chk("trap_set", trap, 1);
    chk("trap_in_ready", in_ready, 0);
    in_op = OP_ADD; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    in_valid = 1'b0;
    chk("trap_sticky", trap, 1);
    chk("trap_no_beat", out_valid, 0);
    chk("trap_in_ready_hold", in_ready, 0);

    #2 rst_n = 1'b0;
    #1;
    chk("trap_rst_async", trap, 0);
    step();
    rst_n = 1'b1;
    m_st = 3'b000;
    step();
    chk("trap_rst_ready", in_ready, 1);

    out_ready = 1'b0;
    send(OP_ADD, 1'b1, 20'h00001, 20'hFFFFF);
    step();
    chk("mid_resp_valid", out_valid, 1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_status", status, 0);
    chk("mid_rst_data", out_data, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_no_beat", out_valid, 0);
    out_ready = 1'b1;
    send(OP_ADD, 1'b1, 20'h00002, 20'h00003);
    recv(20'h00005, 1'b1, 0, "post_rst");
    chk("post_rst_status", status, 3'b000);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
